// File: rtl/simon_pkg.sv
// Shared Simon Says definitions: arrow codes, fail causes and the input checker state encoding.
package simon_pkg;

    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_DOWN  = 3'b001;
    localparam logic [2:0] DIR_UP    = 3'b010;
    localparam logic [2:0] DIR_RIGHT = 3'b011;
    localparam logic [2:0] DIR_NONE  = 3'b111;

    localparam logic [1:0] FAIL_NONE    = 2'b00;
    localparam logic [1:0] FAIL_WRONG   = 2'b01;
    localparam logic [1:0] FAIL_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RELEASE,
        ST_FETCH,
        ST_WAIT_PRESS,
        ST_PASS,
        ST_FAIL
    } chk_state_t;

    // Codes 100..111 all mean "no arrow pressed".
    function automatic logic is_press(input logic [2:0] d);
        return ~d[2];
    endfunction

endpackage

// File: rtl/press_timer.sv
// Per-press timeout counter: clears, counts while enabled and holds at terminal count.
module press_timer #(
    parameter int  TIMEOUT_CYCLES = 250000000,
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    assign tc = (count == TC_VAL);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (en && !tc)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/player_input_checker.sv
// Compares registered arrow presses against the stored sequence for one round and
// reports pass, wrong-arrow fail or timeout fail to the game controller.
module player_input_checker
    import simon_pkg::*;
#(
    parameter int  MAX_LEN        = 16,
    parameter int  TIMEOUT_CYCLES = 250000000,
    localparam int IDX_W          = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W:0]   round_len,
    input  logic [2:0]       direction_in,
    output logic [IDX_W-1:0] exp_addr,
    input  logic [2:0]       exp_dir,
    output logic             busy,
    output logic             round_pass,
    output logic             round_fail,
    output logic [1:0]       fail_cause,
    output logic [IDX_W:0]   press_count,
    output logic [2:0]       arrow_echo
);

    localparam logic [IDX_W:0] MAX_LEN_W = (IDX_W+1)'(MAX_LEN);

    chk_state_t     state;
    logic [2:0]     dir_q;
    logic [IDX_W:0] len_q;
    logic [IDX_W:0] next_count;
    logic           legal_len;
    logic           tmr_tc;

    assign legal_len  = (round_len != '0) && (round_len <= MAX_LEN_W);
    assign next_count = press_count + 1'b1;

    // FETCH always precedes WAIT_PRESS, so clearing there gives a fresh count on entry.
    press_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_FETCH),
        .en    (state == ST_WAIT_PRESS),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            dir_q       <= DIR_NONE;
            len_q       <= '0;
            exp_addr    <= '0;
            busy        <= 1'b0;
            round_pass  <= 1'b0;
            round_fail  <= 1'b0;
            fail_cause  <= FAIL_NONE;
            press_count <= '0;
            arrow_echo  <= DIR_NONE;
        end else begin
            dir_q      <= direction_in;
            round_pass <= 1'b0;
            round_fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && legal_len) begin
                        state       <= ST_WAIT_RELEASE;
                        busy        <= 1'b1;
                        len_q       <= round_len;
                        exp_addr    <= '0;
                        press_count <= '0;
                        fail_cause  <= FAIL_NONE;
                    end
                end
                // A key still down from start or from the last press must lift first.
                ST_WAIT_RELEASE: begin
                    if (!is_press(dir_q))
                        state <= ST_FETCH;
                end
                ST_FETCH: state <= ST_WAIT_PRESS;
                ST_WAIT_PRESS: begin
                    if (is_press(dir_q)) begin
                        arrow_echo <= dir_q;
                        if (dir_q == exp_dir) begin
                            press_count <= next_count;
                            if (next_count == len_q) begin
                                state      <= ST_PASS;
                                round_pass <= 1'b1;
                            end else begin
                                exp_addr <= exp_addr + 1'b1;
                                state    <= ST_WAIT_RELEASE;
                            end
                        end else begin
                            fail_cause <= FAIL_WRONG;
                            state      <= ST_FAIL;
                            round_fail <= 1'b1;
                        end
                    end else if (tmr_tc) begin
                        fail_cause <= FAIL_TIMEOUT;
                        state      <= ST_FAIL;
                        round_fail <= 1'b1;
                    end
                end
                ST_PASS, ST_FAIL: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_input_checker.sv
// Scoreboard bench for player_input_checker with a one-cycle RAM holding UP,LEFT,RIGHT,DOWN.
module tb_player_input_checker;
    import simon_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 20;
    localparam int IDX_W   = $clog2(MAX_LEN);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [IDX_W:0]   round_len;
    logic [2:0]       direction_in;
    logic [IDX_W-1:0] exp_addr;
    logic [2:0]       exp_dir;
    logic             busy, round_pass, round_fail;
    logic [1:0]       fail_cause;
    logic [IDX_W:0]   press_count;
    logic [2:0]       arrow_echo;

    player_input_checker #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .round_len(round_len),
        .direction_in(direction_in), .exp_addr(exp_addr), .exp_dir(exp_dir),
        .busy(busy), .round_pass(round_pass), .round_fail(round_fail),
        .fail_cause(fail_cause), .press_count(press_count), .arrow_echo(arrow_echo)
    );

    always #5 clk = ~clk;

    logic [2:0] mem [0:MAX_LEN-1];
    initial begin
        for (int i = 0; i < MAX_LEN; i++) mem[i] = DIR_NONE;
        mem[0] = DIR_UP; mem[1] = DIR_LEFT; mem[2] = DIR_RIGHT; mem[3] = DIR_DOWN;
    end
    always @(posedge clk) exp_dir <= mem[exp_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pass;
        int cause;
        int cnt;
        int echo;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int p, input int cause, input int cnt, input int echo, input int at);
        exp_t e;
        e.pass = p; e.cause = cause; e.cnt = cnt; e.echo = echo; e.at = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (round_pass || round_fail) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: pass=%0b fail=%0b at cycle %0d, expected none",
                         round_pass, round_fail, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_pass",  int'(round_pass), mon_e.pass);
                chk("pulse_fail",  int'(round_fail), 1 - mon_e.pass);
                chk("fail_cause",  int'(fail_cause), mon_e.cause);
                chk("press_count", int'(press_count), mon_e.cnt);
                chk("arrow_echo",  int'(arrow_echo), mon_e.echo);
                chk("pulse_cycle", cyc, mon_e.at);
            end
        end
    end

    // All tasks enter and leave on a falling edge.
    task automatic do_start(input int n);
        start = 1'b1;
        round_len = (IDX_W+1)'(n);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] d);
        direction_in = d;
        @(negedge clk);
        direction_in = DIR_NONE;
        repeat (5) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int bad_len [2];
        bad_len[0] = 0;
        bad_len[1] = 17;
        reset = 1'b1; start = 1'b0; round_len = '0; direction_in = DIR_NONE;
        repeat (3) @(negedge clk);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_pass",  int'(round_pass), 0);
        chk("rst_fail",  int'(round_fail), 0);
        chk("rst_cause", int'(fail_cause), 0);
        chk("rst_count", int'(press_count), 0);
        chk("rst_addr",  int'(exp_addr), 0);
        chk("rst_echo",  int'(arrow_echo), 7);
        reset = 1'b0;
        @(negedge clk);

        // correct round
        do_start(4);
        chk("busy_after_start", int'(busy), 1);
        press(DIR_UP); press(DIR_LEFT); press(DIR_RIGHT);
        push(1, 0, 4, 1, cyc + 2);
        press(DIR_DOWN);
        drain("correct_drain");
        chk("correct_idle", int'(busy), 0);

        // wrong arrow
        do_start(4);
        press(DIR_UP);
        push(0, 1, 1, 1, cyc + 2);
        press(DIR_DOWN);
        drain("wrong_drain");
        chk("wrong_cause_held", int'(fail_cause), 1);

        // timeout with no input
        push(0, 2, 0, 1, cyc + 23);
        do_start(2);
        drain("timeout_drain");

        // press on the terminal cycle wins over the timeout
        c = cyc;
        do_start(2);
        while (cyc < c + 21) @(negedge clk);
        press(DIR_UP);
        push(1, 0, 2, 0, cyc + 2);
        press(DIR_LEFT);
        drain("terminal_drain");

        // key held from before start
        direction_in = DIR_UP;
        @(negedge clk);
        do_start(2);
        repeat (25) @(negedge clk);
        chk("held_no_count", int'(press_count), 0);
        push(0, 2, 0, 0, cyc + 23);
        direction_in = DIR_NONE;
        drain("held_drain");

        // key held after a correct press counts once
        do_start(2);
        direction_in = DIR_UP;
        repeat (30) @(negedge clk);
        chk("held_once", int'(press_count), 1);
        direction_in = DIR_NONE;
        repeat (5) @(negedge clk);
        push(1, 0, 2, 0, cyc + 2);
        press(DIR_LEFT);
        drain("held_once_drain");

        // illegal lengths are ignored
        foreach (bad_len[i]) begin
            start = 1'b1;
            round_len = (IDX_W+1)'(bad_len[i]);
            @(negedge clk);
            start = 1'b0;
            chk("illegal_busy_a", int'(busy), 0);
            @(negedge clk);
            chk("illegal_busy_b", int'(busy), 0);
        end

        // start while busy is ignored
        do_start(2);
        press(DIR_UP);
        start = 1'b1;
        round_len = 5'd4;
        @(negedge clk);
        start = 1'b0;
        chk("overlap_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        chk("overlap_count", int'(press_count), 1);
        push(1, 0, 2, 0, cyc + 2);
        press(DIR_LEFT);
        drain("overlap_drain");

        // reset mid-round
        do_start(4);
        press(DIR_UP);
        press(DIR_LEFT);
        chk("pre_reset_count", int'(press_count), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_count", int'(press_count), 0);
        chk("mid_rst_echo",  int'(arrow_echo), 7);
        chk("mid_rst_cause", int'(fail_cause), 0);
        chk("mid_rst_addr",  int'(exp_addr), 0);
        repeat (30) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
